// File: rtl/buffer_pkg.sv
// Shared types for the word buffer controller.
// State encoding is also visible on the top-level state port.
package buffer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/ptr_counter.sv
// Wrapping BIT-bit buffer pointer advancing by STEP per enable.
// Wrap comes for free from BIT-bit arithmetic since depth is 2**BIT.
module ptr_counter #(
   parameter int BIT  = 4,
   parameter int STEP = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   output logic [BIT-1:0] ptr
);

   localparam logic [BIT-1:0] STEP_W = BIT'(STEP);

   logic [BIT-1:0] ptr_q;
   logic [BIT-1:0] ptr_d;

   // next pointer: clear wins over advance
   always_comb begin
      ptr_d = ptr_q;
      if (clr)
         ptr_d = '0;
      else if (en)
         ptr_d = ptr_q + STEP_W;
   end

   // pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Beat-based buffer controller: K-word writes, J-word reads, flush FSM.
// Optional sticky protocol error flag enabled by BUFFER_CTRL_ERR_EN.
module buffer_ctrl
   import buffer_pkg::*;
#(
   parameter int SIZE = 16,
   parameter int K    = 4,
   parameter int J    = 8,
   localparam int BIT = $clog2(SIZE)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           out_ready,
   output logic           out_valid,
   input  logic           flush,
   output logic           ld,
   output logic [BIT-1:0] write_add,
   output logic [BIT-1:0] read_add,
   output logic [BIT:0]   count,
   output logic [1:0]     state
`ifdef BUFFER_CTRL_ERR_EN
  ,output logic           err
`endif
);

   localparam logic [BIT:0] SZ_W = (BIT+1)'(SIZE);
   localparam logic [BIT:0] K_W  = (BIT+1)'(K);
   localparam logic [BIT:0] J_W  = (BIT+1)'(J);

   state_t       state_q;
   state_t       state_d;
   logic [BIT:0] occ_q;
   logic [BIT:0] occ_d;
   logic [BIT:0] room;
   logic         wr_beat;
   logic         rd_beat;
   logic         clr;

   assign room      = SZ_W - occ_q;
   assign in_ready  = (state_q == RUN) && (room >= K_W);
   assign out_valid = (state_q == RUN) && (occ_q >= J_W);
   assign wr_beat   = in_valid & in_ready;
   assign rd_beat   = out_valid & out_ready;
   assign ld        = wr_beat;
   assign clr       = (state_q == FLUSH);

   // next state and occupancy from pre-edge occupancy
   always_comb begin
      state_d = state_q;
      occ_d   = occ_q;
      unique case (state_q)
         IDLE:    state_d = RUN;
         RUN: begin
            occ_d = occ_q + (wr_beat ? K_W : '0) - (rd_beat ? J_W : '0);
            if (flush)
               state_d = FLUSH;
         end
         FLUSH: begin
            occ_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
      end
   end

   ptr_counter #(.BIT(BIT), .STEP(K)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (wr_beat),
      .ptr (write_add)
   );

   ptr_counter #(.BIT(BIT), .STEP(J)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (rd_beat),
      .ptr (read_add)
   );

   assign count = occ_q;
   assign state = state_q;

`ifdef BUFFER_CTRL_ERR_EN
   logic err_q;
   logic err_d;

   // sticky flag for offers/requests the buffer cannot honour
   always_comb begin
      err_d = err_q;
      if (state_q == FLUSH)
         err_d = 1'b0;
      else if ((state_q == RUN) &&
               ((in_valid && (room < K_W)) ||
                (out_ready && (occ_q < J_W))))
         err_d = 1'b1;
   end

   // error flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule
